// File: rtl/gradient_seq_pkg.sv
// Shared types and constants for the gradient frame sequencer.
// Holds the FSM encoding, coordinate widths and the pipeline bundle.
package gradient_seq_pkg;

    localparam int COORD_X_W = 10;
    localparam int COORD_Y_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic                 valid;
        logic [COORD_X_W-1:0] x;
        logic [COORD_Y_W-1:0] y;
    } coord_t;

    // Two line buffers plus a small margin for the memory and compute stages.
    function automatic int default_drain(input int width);
        return 2 * width + 8;
    endfunction

endpackage

// File: rtl/pixel_coord_delay.sv
// Delays the issued-read coordinates so they line up with frame-buffer data.
// A flush clears every stage so no stale pixel leaks out after an abort.
module pixel_coord_delay
    import gradient_seq_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [COORD_X_W-1:0] x_i,
    input  logic [COORD_Y_W-1:0] y_i,
    output logic                 valid_o,
    output logic [COORD_X_W-1:0] x_o,
    output logic [COORD_Y_W-1:0] y_o
);

    coord_t stage_q [LATENCY];
    coord_t in_d;

    always_comb begin
        in_d       = '0;
        in_d.valid = valid_i;
        in_d.x     = x_i;
        in_d.y     = y_i;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_d;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[LATENCY-1].valid;
    assign x_o     = stage_q[LATENCY-1].x;
    assign y_o     = stage_q[LATENCY-1].y;

endmodule

// File: rtl/gradient_frame_sequencer.sv
// Frame-level raster scan controller with ping-pong bank pointer,
// drain timer, completion pulse and gradient output counting.
module gradient_frame_sequencer
    import gradient_seq_pkg::*;
#(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int ADDR_WIDTH   = 17,
    parameter int MEM_LATENCY  = 1,
    parameter int DRAIN_CYCLES = default_drain(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pixel_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  curr_bank,
    output logic                  pixel_valid,
    output logic [COORD_X_W-1:0]  pixel_x,
    output logic [COORD_Y_W-1:0]  pixel_y,
    input  logic                  grad_valid,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count,
    output logic [ADDR_WIDTH-1:0] grad_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);

    localparam logic [COORD_X_W-1:0] X_LAST =
        COORD_X_W'(WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST =
        ADDR_WIDTH'(WIDTH * HEIGHT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE =
        DRAIN_W'(1);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COORD_X_W-1:0]  x_q, x_d;
    logic [COORD_Y_W-1:0]  y_q, y_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  bank_q, bank_d;
    logic [15:0]           fcnt_q, fcnt_d;
    logic [ADDR_WIDTH-1:0] gcnt_q, gcnt_d;
    logic                  issue;
    logic                  kill;

    assign issue = (state_q == STREAM) && pixel_en;
    assign kill  = abort && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        drain_d = drain_q;
        bank_d  = bank_q;
        fcnt_d  = fcnt_q;
        gcnt_d  = gcnt_q;

        if (busy && grad_valid) begin
            gcnt_d = gcnt_q + 1'b1;
        end

        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = STREAM;
                        addr_d  = '0;
                        x_d     = '0;
                        y_d     = '0;
                        gcnt_d  = '0;
                    end
                end
                STREAM: begin
                    if (issue) begin
                        addr_d = addr_q + 1'b1;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        if (addr_q == A_LAST) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    // Leave on the last counted drain cycle.
                    if (drain_q <= DRAIN_ONE) begin
                        state_d = DONE;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    bank_d  = ~bank_q;
                    fcnt_d  = fcnt_q + 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drain_q <= '0;
            bank_q  <= 1'b0;
            fcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            bank_q  <= bank_d;
            fcnt_q  <= fcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    pixel_coord_delay #(
        .LATENCY (MEM_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .flush_i (kill),
        .valid_i (issue),
        .x_i     (x_q),
        .y_i     (y_q),
        .valid_o (pixel_valid),
        .x_o     (pixel_x),
        .y_o     (pixel_y)
    );

    assign rd_en       = issue;
    assign rd_addr     = addr_q;
    assign curr_bank   = bank_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign frame_count = fcnt_q;
    assign grad_count  = gcnt_q;

endmodule

// File: tb/tb_gradient_frame_sequencer.sv
// Self-checking bench: vector table, arithmetic frame model, corner sequences.
// Expected timing is derived from read counts and the drain length.
module tb_gradient_frame_sequencer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 17;
    localparam int ML = 1;
    localparam int D  = 20;
    localparam int P  = W * H;

    logic          clk = 1'b0;
    logic          rst, start, abort, pixel_en, grad_valid;
    logic          rd_en, curr_bank, pixel_valid, busy, done;
    logic [AW-1:0] rd_addr, grad_count;
    logic [9:0]    pixel_x;
    logic [8:0]    pixel_y;
    logic [15:0]   frame_count;

    int errors = 0;
    int checks = 0;
    int bank_exp = 0;
    int fc_exp = 0;
    int gc_exp = 0;

    always #5 clk = ~clk;

    gradient_frame_sequencer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .ADDR_WIDTH   (AW),
        .MEM_LATENCY  (ML),
        .DRAIN_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pixel_en    (pixel_en),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .curr_bank   (curr_bank),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .grad_valid  (grad_valid),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count),
        .grad_count  (grad_count)
    );

    typedef struct {
        logic st, ab, pe;
        logic busy, rd, pv, chk_addr;
        int   addr, x, y;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic st, input logic ab,
                         input logic pe, input logic gv);
        @(negedge clk);
        rst        = r;
        start      = st;
        abort      = ab;
        pixel_en   = pe;
        grad_valid = gv;
        #1;
    endtask

    task automatic check_bank_fc();
        check("curr_bank", int'(curr_bank), bank_exp);
        check("frame_count", int'(frame_count), fc_exp);
    endtask

    // mode 0: pixel_en=1, 1: toggling 1,0, 2: random pixel_en/start.
    task automatic run_frame(input int mode, input int ngrad,
                             input int abort_at,
                             output int done_t, output int npv);
        int   k, last, prev, gsent;
        logic pe, gv, st;
        k = 0; last = -1; prev = -1; gsent = 0;
        done_t = -1; npv = 0;
        drive(0, 1, 0, 1, 0);
        check("idle_at_start", int'(busy), 0);
        check("gc_held", int'(grad_count), gc_exp);
        check_bank_fc();
        for (int t = 1; t < 3000; t++) begin
            case (mode)
                0:       pe = 1'b1;
                1:       pe = (t % 2) == 1;
                default: pe = 1'($urandom % 2);
            endcase
            gv = 1'b0;
            if (k < P && gsent < ngrad)
                gv = (mode == 2) ? 1'($urandom % 2) : 1'b1;
            st = (mode == 2) ? 1'($urandom % 2) : 1'b0;
            drive(0, st, t == abort_at, pe, gv);
            if (t == 1) check("gc_cleared", int'(grad_count), 0);
            check("busy", int'(busy), 1);
            check("pixel_valid", int'(pixel_valid), int'(prev >= 0));
            if (prev >= 0) begin
                check("pixel_x", int'(pixel_x), prev % W);
                check("pixel_y", int'(pixel_y), prev / W);
                npv++;
            end
            if (k < P) begin
                check("rd_en", int'(rd_en), int'(pe));
                check("rd_addr", int'(rd_addr), k);
                check("done_stream", int'(done), 0);
            end else begin
                check("rd_en_drain", int'(rd_en), 0);
                check("done", int'(done), int'(t == last + D + 1));
            end
            if (gv) gsent++;
            if (t == abort_at) begin
                drive(0, 0, 0, 1, 0);
                check("abort_busy", int'(busy), 0);
                check("abort_pv", int'(pixel_valid), 0);
                check("abort_done", int'(done), 0);
                check("abort_rd_en", int'(rd_en), 0);
                check_bank_fc();
                gc_exp = gsent;
                return;
            end
            if (k < P && pe) begin
                prev = k;
                k++;
                if (k == P) last = t;
            end else begin
                prev = -1;
            end
            if (last >= 0 && t == last + D + 1) begin
                done_t = t;
                check("gc_at_done", int'(grad_count), gsent);
                bank_exp = 1 - bank_exp;
                fc_exp++;
                gc_exp = gsent;
                return;
            end
        end
        errors++;
        checks++;
        $display("FAIL frame_timeout: got no done expected one");
    endtask

    initial begin
        int dt, npv;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pixel_en = 1'b0; grad_valid = 1'b0;

        tbl[0]  = '{0,0,1, 0,0,0,0, 0,0,0};
        tbl[1]  = '{1,1,1, 0,0,0,0, 0,0,0};
        tbl[2]  = '{0,0,1, 0,0,0,0, 0,0,0};
        tbl[3]  = '{1,0,0, 0,0,0,0, 0,0,0};
        tbl[4]  = '{0,0,0, 1,0,0,1, 0,0,0};
        tbl[5]  = '{0,0,1, 1,1,0,1, 0,0,0};
        tbl[6]  = '{1,0,1, 1,1,1,1, 1,0,0};
        tbl[7]  = '{0,0,0, 1,0,1,1, 2,1,0};
        tbl[8]  = '{0,1,1, 1,1,0,1, 2,0,0};
        tbl[9]  = '{0,0,1, 0,0,0,0, 0,0,0};
        tbl[10] = '{1,0,1, 0,0,0,0, 0,0,0};
        tbl[11] = '{0,0,1, 1,1,0,1, 0,0,0};
        tbl[12] = '{0,1,1, 1,1,1,1, 1,0,0};
        tbl[13] = '{0,0,0, 0,0,0,0, 0,0,0};

        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_pv", int'(pixel_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(rd_addr), 0);
        check("rst_gc", int'(grad_count), 0);
        check_bank_fc();

        for (int i = 0; i < 14; i++) begin
            drive(0, tbl[i].st, tbl[i].ab, tbl[i].pe, 0);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
            check($sformatf("vec%0d_rd_en", i), int'(rd_en), int'(tbl[i].rd));
            check($sformatf("vec%0d_pv", i), int'(pixel_valid), int'(tbl[i].pv));
            check($sformatf("vec%0d_done", i), int'(done), 0);
            if (tbl[i].chk_addr)
                check($sformatf("vec%0d_addr", i), int'(rd_addr), tbl[i].addr);
            if (tbl[i].pv) begin
                check($sformatf("vec%0d_x", i), int'(pixel_x), tbl[i].x);
                check($sformatf("vec%0d_y", i), int'(pixel_y), tbl[i].y);
            end
        end
        check_bank_fc();

        run_frame(0, 25, -1, dt, npv);
        check("done_cycle_full", dt, 53);
        check("pv_count_full", npv, P);
        run_frame(1, 10, -1, dt, npv);
        check("done_cycle_toggle", dt, 84);
        check("pv_count_toggle", npv, P);
        run_frame(2, 12, -1, dt, npv);
        check("pv_count_rand", npv, P);

        drive(0, 0, 0, 1, 1);
        check("b2b_bank", int'(curr_bank), 1);
        check("b2b_fc", int'(frame_count), 3);
        drive(0, 0, 0, 1, 0);
        check("gc_held_idle", int'(grad_count), gc_exp);

        run_frame(0, 4, 10, dt, npv);
        drive(0, 0, 0, 1, 0);
        check_bank_fc();

        drive(0, 1, 0, 1, 0);
        for (int i = 1; i <= P + 5; i++) drive(0, 0, 0, 1, 1'(i <= 5));
        check("drain_busy", int'(busy), 1);
        check("drain_rd_en", int'(rd_en), 0);
        check("drain_gc", int'(grad_count), 5);
        drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        check("rstd_busy", int'(busy), 0);
        check("rstd_rd_en", int'(rd_en), 0);
        check("rstd_pv", int'(pixel_valid), 0);
        check("rstd_addr", int'(rd_addr), 0);
        check("rstd_x", int'(pixel_x), 0);
        check("rstd_y", int'(pixel_y), 0);
        check("rstd_gc", int'(grad_count), 0);
        bank_exp = 0; fc_exp = 0; gc_exp = 0;
        check_bank_fc();

        run_frame(2, 20, -1, dt, npv);
        check("pv_count_rand2", npv, P);
        drive(0, 0, 0, 0, 0);
        check_bank_fc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gradient_frame_sequencer.md
# gradient_frame_sequencer

Frame-level controller for the gradient datapath: on a start pulse it raster-scans the two frame-buffer banks (current and previous), drives `pixel_valid`/coordinates into `gradient_compute` aligned with read data, drains the line-buffer pipeline, and signals completion. It owns the ping-pong bank pointer, swapping current/previous after every completed frame, and counts gradient outputs for sanity checking. It sits between the frame-buffer memories and `gradient_compute`, under the top-level flow controller.

## Interface
Parameters:
- `WIDTH`, 320, frame width in pixels
- `HEIGHT`, 240, frame height in pixels
- `ADDR_WIDTH`, 17, frame-buffer address width (≥ clog2(WIDTH*HEIGHT))
- `MEM_LATENCY`, 1, frame-buffer read latency in cycles (≥1)
- `DRAIN_CYCLES`, 648, flush cycles after last read (default 2*WIDTH+8; must cover MEM_LATENCY + line-buffer latency)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — clock
- `rst` in 1 — synchronous active-high reset
- `start` in 1 — begin one frame; sampled only in IDLE
- `abort` in 1 — cancel current frame
- `pixel_en` in 1 — throttle; a read issues only in cycles where high during STREAM
- `rd_en` out 1 — frame-buffer read strobe (both banks)
- `rd_addr` out ADDR_WIDTH — linear read address, y*WIDTH+x
- `curr_bank` out 1 — bank holding current frame; previous = ~curr_bank
- `pixel_valid` out 1 — to `gradient_compute`, aligned with read data
- `pixel_x` out 10 — column of pixel on `pixel_valid`
- `pixel_y` out 9 — row of pixel on `pixel_valid`
- `grad_valid` in 1 — from `gradient_compute`
- `busy` out 1 — frame in progress
- `done` out 1 — one-cycle completion pulse
- `frame_count` out 16 — completed frames, wraps at 2^16
- `grad_count` out ADDR_WIDTH — `grad_valid` pulses seen in last/current frame

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: `start`=1 and `abort`=0 → STREAM; clear address, x/y counters, `grad_count`.
- STREAM: `rd_en` = `pixel_en` (combinational from registered state). On each issued read: `rd_addr`+1, x+1; x wraps WIDTH-1→0 with y+1. Read of pixel WIDTH*HEIGHT-1 issued → DRAIN, drain counter loaded with DRAIN_CYCLES.
- DRAIN: no reads; `pixel_en` ignored; counter decrements each cycle; after DRAIN_CYCLES cycles → DONE.
- DONE (one cycle): `done`=1, `curr_bank` toggles, `frame_count`+1 (wrapping) at end of cycle → IDLE.
- Coordinate/valid pipeline: issued read's x, y and a valid bit delayed MEM_LATENCY cycles → `pixel_x`, `pixel_y`, `pixel_valid`; non-issue cycles insert valid=0.
- `grad_count` increments on `grad_valid` while `busy`; held after DONE until next accepted start.
- `abort` (any non-IDLE state) → IDLE next cycle; no `done`, no bank swap, no `frame_count` change; delay pipeline flushed (`pixel_valid`=0 from next cycle).
- Priority: `rst` > `abort` > `start`. `start` outside IDLE ignored; `start`+`abort` in IDLE → stay IDLE.
- Reset values: state IDLE; `rd_en`, `pixel_valid`, `busy`, `done` 0; `rd_addr`, `pixel_x`, `pixel_y`, `curr_bank`, `frame_count`, `grad_count` 0; pipeline cleared. Reset mid-frame behaves as abort plus clearing counters and bank pointer.

## Timing
- P = WIDTH*HEIGHT. `start` sampled at cycle 0 → STREAM at cycle 1, first read (addr 0) cycle 1 if `pixel_en`=1.
- `pixel_valid` for a read issued at cycle c asserted at c+MEM_LATENCY, exactly one cycle.
- `pixel_en` held 1: last read cycle P, DRAIN cycles P+1..P+DRAIN_CYCLES, `done` at cycle P+DRAIN_CYCLES+1, `busy` low from cycle P+DRAIN_CYCLES+2.
- `busy` high in STREAM, DRAIN, DONE. Back-to-back: `start` high in the cycle after DONE is accepted.
- Each `pixel_en`-low cycle in STREAM extends the frame by one cycle.

## Structure
- Package `gradient_seq_pkg`: `seq_state_t` enum (IDLE, STREAM, DRAIN, DONE), coordinate widths (10/9), default DRAIN derivation.
- Sub-module `pixel_coord_delay`: MEM_LATENCY-deep shift of {valid, x, y} with synchronous flush input; rest in one FSM + counters module.

## Test plan
- WIDTH=8, HEIGHT=4, MEM_LATENCY=1, DRAIN_CYCLES=20, `pixel_en`=1: start at cycle 0 → `rd_addr` 0..31 at cycles 1..32, `pixel_valid` cycles 2..33 with x wrapping 7→0 and y 0..3, `done` at cycle 53, `curr_bank` 0→1, `frame_count`=1.
- Same config, `pixel_en` toggling 1,0: 32 reads over 63 STREAM cycles, `pixel_valid` count exactly 32, `done` at cycle 84.
- `abort` at cycle 10: `pixel_valid` 0 from cycle 11, IDLE at 11, no `done`, `curr_bank`=0, `frame_count`=0.
- Three back-to-back frames (start the cycle after each `done`): `curr_bank` 1,0,1; `frame_count` 3; no idle gap beyond one cycle.
- `start` pulses during STREAM/DRAIN and `start`+`abort` in IDLE → ignored; `rst` mid-DRAIN → all outputs at reset values next cycle.
- `grad_valid` driven 25 times during a frame → `grad_count`=25 at `done`, held until next start, cleared to 0 on start acceptance.
